// File: rtl/telemetry_framer.sv
// ---------------------------------------------------------------------------
// telemetry_framer
//
// Buffers multi-channel controller telemetry snapshots and serialises them
// as byte frames towards uart_tx. A frame is:
//   SYNC0, SYNC1, seq, payload (channel NUM_CH-1 first, MSB first per word)
//   [, chk]  -- chk only when TELEM_CHECKSUM_EN is defined
//
// Optional feature macro: TELEM_CHECKSUM_EN
//   defined     : one trailing byte chk so (seq + payload + chk) mod 256 == 0
//   not defined : frame ends after the last payload byte, no checksum logic
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   en             in   framer enable; gates captures and new frame starts
//   sample_stb     in   one-cycle strobe: capture sample_data
//   sample_data    in   NUM_CH*WORD_BYTES*8 snapshot, channel NUM_CH-1 in MS word
//   tx_done        in   one-cycle pulse from uart_tx when a byte is finished
//   tx_start       out  one-cycle pulse: uart_tx loads tx_din
//   tx_din         out  byte to transmit (0 while idle)
//   busy           out  high while a frame is in flight
//   frames_dropped out  snapshots rejected on a full buffer, saturating
// ---------------------------------------------------------------------------
module telemetry_framer #(
    parameter int         NUM_CH      = 7,
    parameter int         WORD_BYTES  = 4,
    parameter int         DEPTH_POW_2 = 4,
    parameter logic [7:0] SYNC0       = 8'hA5,
    parameter logic [7:0] SYNC1       = 8'h5A
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           sample_stb,
    input  logic [NUM_CH*WORD_BYTES*8-1:0] sample_data,
    input  logic                           tx_done,
    output logic                           tx_start,
    output logic [7:0]                     tx_din,
    output logic                           busy,
    output logic [15:0]                    frames_dropped
);

    localparam int PAY_BYTES = NUM_CH * WORD_BYTES;
    localparam int SNAP_W    = PAY_BYTES * 8;
    localparam int DEPTH     = 1 << DEPTH_POW_2;
`ifdef TELEM_CHECKSUM_EN
    localparam int FRAME_LEN = 4 + PAY_BYTES;
`else
    localparam int FRAME_LEN = 3 + PAY_BYTES;
`endif
    localparam int               IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] FIRST_PAY = IDX_W'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    state_t state, next_state;

    // Snapshot buffer; pointers carry one extra wrap bit so full/empty are exact.
    logic [SNAP_W-1:0]    mem [DEPTH];
    logic [DEPTH_POW_2:0] wr_ptr, rd_ptr;
    logic                 empty, full, pop, push, drop;

    logic [SNAP_W-1:0] payload_reg;
    logic [IDX_W-1:0]  byte_idx;
    logic [7:0]        seq;
    logic [7:0]        cur_byte;
`ifdef TELEM_CHECKSUM_EN
    logic [7:0]        chk_acc;
`endif

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_POW_2] != rd_ptr[DEPTH_POW_2]) &&
                   (wr_ptr[DEPTH_POW_2-1:0] == rd_ptr[DEPTH_POW_2-1:0]);

    // A pop in the same cycle frees a slot, so a strobe on a full buffer
    // still gets in when a frame starts at that edge.
    assign pop  = (state == S_IDLE) && en && !empty;
    assign push = sample_stb && en && (!full || pop);
    assign drop = sample_stb && en && full && !pop;

    // Snapshot storage needs no reset: only slots behind wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_POW_2-1:0]] <= sample_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            frames_dropped <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop && (frames_dropped != 16'hFFFF)) begin
                frames_dropped <= frames_dropped + 16'd1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (pop) next_state = S_SEND;
            S_SEND: next_state = S_WAIT;
            S_WAIT: begin
                if (tx_done) begin
                    next_state = (byte_idx == LAST_IDX) ? S_IDLE : S_SEND;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Frame datapath: the payload is shifted left after each payload byte so
    // the byte on air is always the top byte of payload_reg.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            payload_reg <= '0;
            byte_idx    <= '0;
            seq         <= '0;
`ifdef TELEM_CHECKSUM_EN
            chk_acc     <= '0;
`endif
        end else if (pop) begin
            payload_reg <= mem[rd_ptr[DEPTH_POW_2-1:0]];
            byte_idx    <= '0;
`ifdef TELEM_CHECKSUM_EN
            chk_acc     <= seq;
`endif
        end else if ((state == S_WAIT) && tx_done) begin
            if (byte_idx == LAST_IDX) begin
                byte_idx <= '0;
                seq      <= seq + 8'd1;
            end else begin
                byte_idx <= byte_idx + IDX_W'(1);
                if (byte_idx >= FIRST_PAY) begin
                    payload_reg <= payload_reg << 8;
`ifdef TELEM_CHECKSUM_EN
                    chk_acc     <= chk_acc + payload_reg[SNAP_W-1 -: 8];
`endif
                end
            end
        end
    end

    // Byte selection for the current frame position
    always_comb begin
        cur_byte = payload_reg[SNAP_W-1 -: 8];
        if (byte_idx == IDX_W'(0)) begin
            cur_byte = SYNC0;
        end else if (byte_idx == IDX_W'(1)) begin
            cur_byte = SYNC1;
        end else if (byte_idx == IDX_W'(2)) begin
            cur_byte = seq;
        end
`ifdef TELEM_CHECKSUM_EN
        else if (byte_idx == LAST_IDX) begin
            cur_byte = 8'h00 - chk_acc;
        end
`endif
    end

    // FSM outputs; tx_din is held stable for the whole byte and is 0 when idle.
    always_comb begin
        tx_start = (state == S_SEND);
        busy     = (state != S_IDLE);
        tx_din   = busy ? cur_byte : 8'h00;
    end

endmodule

// File: tb/tb_telemetry_framer.sv
// ---------------------------------------------------------------------------
// tb_telemetry_framer
//
// Scoreboard bench for telemetry_framer (NUM_CH=2, WORD_BYTES=1,
// DEPTH_POW_2=1). Stimulus pushes the expected frame bytes into a queue; a
// monitor pops and compares on every tx_start. A responder returns tx_done a
// programmable number of cycles after each tx_start, or withholds it.
// ---------------------------------------------------------------------------
module tb_telemetry_framer;

    typedef struct {
        logic [7:0] b;
        bit         gap;
        bit         last;
        int         idx;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        en;
    logic        sample_stb;
    logic [15:0] sample_data;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        busy;
    logic [15:0] frames_dropped;

    exp_t        exp_q[$];
    logic [7:0]  exp_seq;
    logic [7:0]  last_seq_seen;
    int          tests_run;
    int          failures;
    int          cyc;
    int          last_done;
    int          start_count;
    int          done_delay;
    bit          hold_done;
    bit          awaiting_last;
    bit          check_idle;

`ifdef TELEM_CHECKSUM_EN
    localparam int L = 6;
`else
    localparam int L = 5;
`endif

    telemetry_framer #(
        .NUM_CH     (2),
        .WORD_BYTES (1),
        .DEPTH_POW_2(1),
        .SYNC0      (8'hA5),
        .SYNC1      (8'h5A)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .sample_stb    (sample_stb),
        .sample_data   (sample_data),
        .tx_done       (tx_done),
        .tx_start      (tx_start),
        .tx_din        (tx_din),
        .busy          (busy),
        .frames_dropped(frames_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Expected frame for one accepted snapshot, using the bench's own seq count.
    task automatic push_frame(input logic [15:0] data, input bit gap_first);
        logic [7:0] fb [6];
        fb[0] = 8'hA5;
        fb[1] = 8'h5A;
        fb[2] = exp_seq;
        fb[3] = data[15:8];
        fb[4] = data[7:0];
        fb[5] = 8'h00 - (exp_seq + data[15:8] + data[7:0]);
        for (int i = 0; i < L; i++) begin
            exp_q.push_back('{b: fb[i], gap: (i == 0) && gap_first, last: (i == L - 1), idx: i});
        end
        exp_seq = exp_seq + 8'd1;
    endtask

    // One-cycle strobe; call right after a posedge (+#1). Consecutive calls give
    // back-to-back strobes.
    task automatic applyStimulus(input logic [15:0] data);
        sample_data = data;
        sample_stb  = 1'b1;
        @(posedge clk);
        #1;
        sample_stb  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((exp_q.size() == 0) && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests_run++;
            failures++;
            $display("[TB] FAIL wait_idle: timeout, %0d bytes outstanding, busy=%0b", exp_q.size(), busy);
        end
    endtask

    // tx_done responder
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !reset) begin
                while (hold_done) @(negedge clk);
                repeat (done_delay) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Monitor: compares every transmitted byte against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            awaiting_last = 1'b0;
            check_idle    = 1'b0;
        end else begin
            if (check_idle) begin
                checkOutput("busy_after_last_done", {31'd0, busy}, 32'd0);
                check_idle = 1'b0;
            end
            if (tx_done) begin
                last_done = cyc;
                if (awaiting_last) begin
                    checkOutput("busy_at_last_done", {31'd0, busy}, 32'd1);
                    awaiting_last = 1'b0;
                    check_idle    = 1'b1;
                end
            end
            if (tx_start) begin
                exp_t e;
                start_count++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    failures++;
                    $display("[TB] FAIL unexpected_tx_start: got byte %0h, expected no transmission", tx_din);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("tx_din[%0d]", e.idx), {24'd0, tx_din}, {24'd0, e.b});
                    if (e.gap) checkOutput("frame_gap", cyc - last_done, 32'd2);
                    if (e.idx == 2) last_seq_seen = tx_din;
                    if (e.last) awaiting_last = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s0;
        tests_run     = 0;
        failures      = 0;
        cyc           = 0;
        last_done     = 0;
        start_count   = 0;
        exp_seq       = 8'h00;
        last_seq_seen = 8'h00;
        done_delay    = 10;
        hold_done     = 1'b0;
        awaiting_last = 1'b0;
        check_idle    = 1'b0;
        reset         = 1'b1;
        en            = 1'b0;
        sample_stb    = 1'b0;
        sample_data   = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_tx_start", {31'd0, tx_start}, 32'd0);
        checkOutput("reset_tx_din", {24'd0, tx_din}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_dropped", {16'd0, frames_dropped}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        en    = 1'b1;

        // Single frame: A5 5A 00 12 34 (+BA)
        @(posedge clk); #1;
        push_frame(16'h1234, 1'b0);
        applyStimulus(16'h1234);
        wait_idle(300);
        checkOutput("seq_first_frame", {24'd0, last_seq_seen}, 32'd0);

        // Three back-to-back snapshots: consecutive frames, 2-cycle gaps
        @(posedge clk); #1;
        push_frame(16'hA1B2, 1'b0);
        push_frame(16'hC3D4, 1'b1);
        push_frame(16'hE5F6, 1'b1);
        applyStimulus(16'hA1B2);
        applyStimulus(16'hC3D4);
        applyStimulus(16'hE5F6);
        wait_idle(800);
        checkOutput("dropped_after_burst", {16'd0, frames_dropped}, 32'd0);

        // Overflow with tx_done withheld: 1 in flight, 2 buffered, 2 dropped
        hold_done = 1'b1;
        @(posedge clk); #1;
        push_frame(16'h0101, 1'b0);
        push_frame(16'h0202, 1'b0);
        push_frame(16'h0303, 1'b0);
        applyStimulus(16'h0101);
        applyStimulus(16'h0202);
        applyStimulus(16'h0303);
        applyStimulus(16'h0404);
        applyStimulus(16'h0505);
        repeat (3) @(negedge clk);
        checkOutput("overflow_dropped", {16'd0, frames_dropped}, 32'd2);
        checkOutput("overflow_busy", {31'd0, busy}, 32'd1);
        hold_done = 1'b0;
        wait_idle(800);

        // Sequence wrap: 257th frame carries seq 00
        done_delay = 1;
        for (int i = 0; i < 249; i++) begin
            @(posedge clk); #1;
            push_frame(16'(i * 37 + 5), 1'b0);
            applyStimulus(16'(i * 37 + 5));
            wait_idle(100);
        end
        checkOutput("seq_frame_256", {24'd0, last_seq_seen}, 32'hFF);
        @(posedge clk); #1;
        push_frame(16'hBEEF, 1'b0);
        applyStimulus(16'hBEEF);
        wait_idle(100);
        checkOutput("seq_wrap_frame_257", {24'd0, last_seq_seen}, 32'd0);

        // en dropped mid-frame: frame completes, strobes while disabled ignored
        done_delay = 10;
        @(posedge clk); #1;
        push_frame(16'h5566, 1'b0);
        applyStimulus(16'h5566);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() <= L - 2) break;
        end
        @(posedge clk); #1;
        en = 1'b0;
        applyStimulus(16'h7788);
        wait_idle(300);
        s0 = start_count;
        applyStimulus(16'h99AA);
        repeat (30) @(negedge clk);
        checkOutput("no_start_while_disabled", start_count - s0, 32'd0);
        checkOutput("no_drop_count_while_disabled", {16'd0, frames_dropped}, 32'd2);
        @(posedge clk); #1;
        en = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("nothing_buffered_while_disabled", start_count - s0, 32'd0);
        checkOutput("idle_after_reenable", {31'd0, busy}, 32'd0);

        // Reset during WAIT: outputs clear at once, next frame starts at seq 00
        hold_done = 1'b1;
        @(posedge clk); #1;
        push_frame(16'hDEAD, 1'b0);
        applyStimulus(16'hDEAD);
        repeat (5) @(negedge clk);
        checkOutput("in_wait_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midframe_reset_tx_start", {31'd0, tx_start}, 32'd0);
        checkOutput("midframe_reset_tx_din", {24'd0, tx_din}, 32'd0);
        checkOutput("midframe_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midframe_reset_dropped", {16'd0, frames_dropped}, 32'd0);
        exp_q.delete();
        exp_seq    = 8'h00;
        done_delay = 1;
        hold_done  = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        push_frame(16'h4242, 1'b0);
        applyStimulus(16'h4242);
        wait_idle(100);
        checkOutput("seq_after_reset", {24'd0, last_seq_seen}, 32'd0);

        // Drop counter saturation at FFFF
        hold_done = 1'b1;
        @(posedge clk); #1;
        push_frame(16'h1111, 1'b0);
        push_frame(16'h2222, 1'b0);
        push_frame(16'h3333, 1'b0);
        applyStimulus(16'h1111);
        applyStimulus(16'h2222);
        applyStimulus(16'h3333);
        sample_data = 16'hFFFF;
        sample_stb  = 1'b1;
        repeat (65534) @(posedge clk);
        #1 sample_stb = 1'b0;
        @(negedge clk);
        checkOutput("dropped_near_max", {16'd0, frames_dropped}, 32'hFFFE);
        @(posedge clk); #1;
        sample_stb = 1'b1;
        repeat (5) @(posedge clk);
        #1 sample_stb = 1'b0;
        @(negedge clk);
        checkOutput("dropped_saturated", {16'd0, frames_dropped}, 32'hFFFF);
        hold_done = 1'b0;
        wait_idle(300);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
